// File: rtl/load_align_ext.sv
// Load-data aligner/extender for the MEM/WB boundary: one- or two-beat loads, valid/ready on both sides.
// Optional counters are enabled by defining LOAD_ALIGN_EXT_STAT_EN.
module load_align_ext #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_size,
  input  logic                in_sign,
  input  logic [OFF_W-1:0]    in_offset,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_misalign,
  output logic [1:0]          dbg_state
`ifdef LOAD_ALIGN_EXT_STAT_EN
  ,
  output logic [15:0]         stat_loads,
  output logic [7:0]          stat_misalign
`endif
);

  // Handshake semantics: a transfer happens on a rising edge where valid && ready
  // are both high; valid, once raised, holds its payload stable until the transfer.
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_HOLD} state_t;

  state_t                r_state;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [OFF_W-1:0]      r_offset;
  logic [DATA_W-1:0]     r_low;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_out_misalign;
  logic [2*DATA_W-1:0]   r_out_data;

  logic                  w_misalign;
  logic [DATA_W-1:0]     w_shifted;
  logic [2*DATA_W-1:0]   w_ext;

  always_comb begin
    w_misalign = 1'b0;
    case (in_size)
      2'd1:    w_misalign = in_offset[0];
      2'd2:    w_misalign = (in_offset[1:0] != 2'b00);
      2'd3:    w_misalign = (in_offset != '0);
      default: w_misalign = 1'b0;
    endcase
  end

  // Field is brought down to bit 0 first, so extension only looks at fixed bit positions.
  always_comb begin
    w_shifted = mem_data >> {r_offset, 3'b000};
    w_ext     = '0;
    case (r_size)
      2'd0:    w_ext = {{(2*DATA_W-8){r_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ext = {{(2*DATA_W-16){r_sign & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_ext = {{(2*DATA_W-32){r_sign & w_shifted[31]}}, w_shifted[31:0]};
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_size         <= 2'd0;
      r_sign         <= 1'b0;
      r_offset       <= '0;
      r_low          <= '0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_misalign <= 1'b0;
      r_out_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_size     <= in_size;
            r_sign     <= in_sign;
            r_offset   <= in_offset;
            r_in_ready <= 1'b0;
            if (w_misalign) begin
              r_out_valid    <= 1'b1;
              r_out_misalign <= 1'b1;
              r_out_data     <= '0;
              r_state        <= S_HOLD;
            end else begin
              r_state <= S_BEAT0;
            end
          end
        end
        S_BEAT0: begin
          if (mem_valid) begin
            if (r_size == 2'd3) begin
              r_low   <= mem_data;
              r_state <= S_BEAT1;
            end else begin
              r_out_data     <= w_ext;
              r_out_valid    <= 1'b1;
              r_out_misalign <= 1'b0;
              r_state        <= S_HOLD;
            end
          end
        end
        S_BEAT1: begin
          if (mem_valid) begin
            r_out_data     <= {mem_data, r_low};
            r_out_valid    <= 1'b1;
            r_out_misalign <= 1'b0;
            r_state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid    <= 1'b0;
            r_out_misalign <= 1'b0;
            r_in_ready     <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOAD_ALIGN_EXT_STAT_EN
  logic [15:0] r_stat_loads;
  logic [7:0]  r_stat_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_loads    <= '0;
      r_stat_misalign <= '0;
    end else if (r_state == S_HOLD && out_ready) begin
      if (r_stat_loads != '1) r_stat_loads <= r_stat_loads + 16'd1;
      if (r_out_misalign && r_stat_misalign != '1) r_stat_misalign <= r_stat_misalign + 8'd1;
    end
  end

  assign stat_loads    = r_stat_loads;
  assign stat_misalign = r_stat_misalign;
`endif

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_misalign = r_out_misalign;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_load_align_ext.sv
// Directed plus randomized bench for load_align_ext at DATA_W=32, checked against
// an arithmetic model of the load rules and an expected-result queue.
module tb_load_align_ext;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_size;
  logic                in_sign;
  logic [1:0]          in_offset;
  logic                mem_valid;
  logic [DATA_W-1:0]   mem_data;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] out_data;
  logic                out_misalign;
  logic [1:0]          dbg_state;
`ifdef LOAD_ALIGN_EXT_STAT_EN
  logic [15:0]         stat_loads;
  logic [7:0]          stat_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int m_loads = 0;
  int m_mis = 0;

  logic [63:0] exp_q[$];
  logic        mis_q[$];

  load_align_ext #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_size(in_size),
    .in_sign(in_sign), .in_offset(in_offset),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misalign(out_misalign), .dbg_state(dbg_state)
`ifdef LOAD_ALIGN_EXT_STAT_EN
    , .stat_loads(stat_loads), .stat_misalign(stat_misalign)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: alignment rules and field extraction by plain arithmetic
  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] off);
    int o;
    o = int'(off);
    if (sz == 2'd1) return (o % 2) != 0;
    if (sz == 2'd2) return (o % 4) != 0;
    if (sz == 2'd3) return o != 0;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                                        input logic [31:0] b0, input logic [31:0] b1);
    int          w;
    logic [63:0] mask;
    logic [63:0] field;
    if (is_mis(sz, off)) return 64'd0;
    if (sz == 2'd3) return (64'(b1) << 32) | 64'(b0);
    w     = 8 << sz;
    mask  = (64'd1 << w) - 64'd1;
    field = (64'(b0) >> (int'(off) * 8)) & mask;
    if (sg && ((field >> (w - 1)) & 64'd1) == 64'd1) field = field | ~mask;
    return field;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks (all driving and sampling on the falling edge)
  task automatic take_out(input int hold_wait);
    logic [63:0] e;
    logic        m;
    e = exp_q.pop_front();
    m = mis_q.pop_front();
    check("out_data", out_data, e);
    check("out_misalign", 64'(out_misalign), 64'(m));
    for (int i = 0; i < hold_wait; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_size   = 2'($urandom_range(0, 3));
      in_offset = 2'($urandom_range(0, 3));
      mem_valid = 1'($urandom_range(0, 1));
      mem_data  = $urandom;
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, e);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    mem_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_loads++;
    if (m) m_mis++;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_misalign", 64'(out_misalign), 64'd0);
  endtask

  task automatic do_load(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                         input logic [31:0] b0, input logic [31:0] b1,
                         input int gap0, input int gap1, input int hold_wait);
    logic mis;
    mis = is_mis(sz, off);
    exp_q.push_back(model(sz, sg, off, b0, b1));
    mis_q.push_back(mis);
    in_valid  = 1'b1;
    in_size   = sz;
    in_sign   = sg;
    in_offset = off;
    check("accept_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_size   = 2'($urandom_range(0, 3));
    in_sign   = 1'($urandom_range(0, 1));
    in_offset = 2'($urandom_range(0, 3));
    if (mis) begin
      check("mis_latency", 64'(out_valid), 64'd1);
    end else begin
      check("busy_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < gap0; i++) begin
        mem_data = $urandom;
        @(negedge clk);
      end
      check("stall_no_valid", 64'(out_valid), 64'd0);
      mem_valid = 1'b1;
      mem_data  = b0;
      @(negedge clk);
      mem_valid = 1'b0;
      mem_data  = $urandom;
      if (sz == 2'd3) begin
        check("dbl_no_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < gap1; i++) @(negedge clk);
        mem_valid = 1'b1;
        mem_data  = b1;
        @(negedge clk);
        mem_valid = 1'b0;
      end
      check("out_latency", 64'(out_valid), 64'd1);
    end
    take_out(hold_wait);
  endtask

  // directed steps, then random loads
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_size = 2'd0; in_sign = 1'b0; in_offset = 2'd0;
    mem_valid = 1'b0; mem_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_misalign", 64'(out_misalign), 64'd0);

    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    mem_valid = 1'b0;
    check("idle_mem_ignored", 64'(out_valid), 64'd0);

    do_load(2'd0, 1'b1, 2'd2, 32'h12F4_5678, 32'h0, 0, 0, 0);
    do_load(2'd1, 1'b0, 2'd2, 32'h8001_ABCD, 32'h0, 0, 0, 0);
    do_load(2'd1, 1'b1, 2'd2, 32'h8001_ABCD, 32'h0, 1, 0, 0);
    do_load(2'd3, 1'b0, 2'd0, 32'h1111_2222, 32'h3333_4444, 0, 3, 0);
    do_load(2'd2, 1'b1, 2'd1, 32'h0, 32'h0, 0, 0, 3);
    do_load(2'd0, 1'b0, 2'd0, 32'h0000_00A5, 32'h0, 0, 0, 0);
    do_load(2'd2, 1'b1, 2'd0, 32'h8765_4321, 32'h0, 2, 0, 5);
    do_load(2'd2, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);

    // reset during the second beat of a double
    in_valid = 1'b1; in_size = 2'd3; in_sign = 1'b0; in_offset = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    mem_valid = 1'b1; mem_data = 32'hAAAA_BBBB;
    @(negedge clk);
    mem_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_loads = 0;
    m_mis = 0;
    check("rst_beat1_valid", 64'(out_valid), 64'd0);
    check("rst_beat1_ready", 64'(in_ready), 64'd1);
    do_load(2'd0, 1'b0, 2'd1, 32'h0000_7700, 32'h0, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      do_load(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef LOAD_ALIGN_EXT_STAT_EN
    check("stat_loads", 64'(stat_loads), 64'(m_loads));
    check("stat_misalign", 64'(stat_misalign), 64'(m_mis));
`endif
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_align_ext.md
Name: load_align_ext

Overview:
Parametrised, handshaked load-data aligner and extender for the MEM/WB boundary. It accepts a load descriptor (size, sign, byte offset) and collects one or two memory beats. It extracts and sign- or zero-extends the addressed field, then holds the registered result until writeback accepts it. Successor to the single-word combinational load extender: adds configurable bus width, byte-offset alignment, two-beat double loads, misalignment detection and a valid/ready handshake.

Parameters:
DATA_W, 32, memory bus width in bits; power of two, >= 32.
OFF_W, log2(DATA_W/8), derived localparam: byte-offset width, 2 at default.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  load descriptor valid
in_ready  output  1  block can accept a descriptor
in_size  input  2  0=byte, 1=half, 2=word(32b), 3=double(2*DATA_W)
in_sign  input  1  1=sign-extend, 0=zero-extend
in_offset  input  OFF_W  byte offset of the field within the bus word
mem_valid  input  1  mem_data carries a beat this cycle
mem_data  input  DATA_W  memory read beat
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  2*DATA_W  extended result
out_misalign  output  1  qualifies out_valid: the load was misaligned, out_data=0

Behaviour:
- Reset (sync): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_misalign=0; captured beat cleared.
- FSM states: IDLE, BEAT0, BEAT1, HOLD.
- IDLE: in_ready=1. On in_valid, latch size, sign and offset.
  - Misaligned (half with offset[0]!=0; word with offset[1:0]!=0; double with offset!=0) -> HOLD next cycle with out_misalign=1, out_data=0. No mem beat consumed.
  - Otherwise -> BEAT0.
- in_ready=0 in every state except IDLE. in_valid is ignored when in_ready=0.
- BEAT0: wait on mem_valid.
  - Size 0-2: extract the field at bit offset*8 and width 8/16/32, extend to 2*DATA_W per latched sign, register to out_data, -> HOLD.
  - Size 3: capture mem_data as the low half, -> BEAT1.
- BEAT1: on mem_valid, out_data = {mem_data, low half} with no extension, -> HOLD.
- HOLD: out_valid=1; out_data and out_misalign stable. On out_ready -> IDLE, out_valid=0 and out_misalign=0 next cycle.
- No turnaround overlap: a new descriptor is accepted at the earliest in the cycle after the out handshake.
- mem_valid outside BEAT0/BEAT1 is ignored (no capture, no error).
- Latency, with accept in cycle N:
  - aligned single beat, mem_valid in N+1 -> out_valid in N+2;
  - double, beats in N+1 and N+2 -> out_valid in N+3;
  - misaligned -> out_valid in N+1.
- A stalled mem_valid extends the BEAT states indefinitely with no timeout.
- Size 2 with DATA_W=32 and offset 0 is the full bus word. It is still extended to 64 bits per sign.
- rst while in any state: abandon the operation, discard partial beats, drop out_valid in the next cycle, return to IDLE.
- out_data bits above the extended field all equal the field MSB (sign) or 0 (zero).

Optional Feature:
LOAD_ALIGN_EXT_STAT_EN
- Defined: adds outputs stat_loads[15:0] and stat_misalign[7:0].
  - stat_loads increments on each completed out handshake.
  - stat_misalign increments on each completed handshake with out_misalign=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Byte, sign=1, offset=2, beat 0x12F4_5678 -> out_data=0xFFFF_FFFF_FFFF_FFF4, out_misalign=0, out_valid 2 cycles after accept.
- Half, sign=0, offset=2, beat 0x8001_ABCD -> out_data=0x0000_0000_0000_8001; repeat with sign=1 -> 0xFFFF_FFFF_FFFF_8001.
- Double, offset=0, beats 0x1111_2222 then 0x3333_4444 with a 3-cycle gap -> out_data=0x3333_4444_1111_2222, out_valid the cycle after the second beat.
- Word at offset=1 -> out_valid next cycle, out_misalign=1, out_data=0; mem_valid pulses during HOLD produce no capture. With STAT_EN, stat_misalign=1.
- out_ready held low 5 cycles -> out_data and out_valid stable, in_ready=0, a second in_valid is ignored; on release, IDLE and in_ready=1 the next cycle.
- rst asserted in BEAT1 -> the next cycle has out_valid=0 and in_ready=1; a following byte load returns only new-beat data.
